// File: rtl/sc_pkg.sv
// sc_pkg: definitions shared by the stochastic-computing matrix decoder.
//   sc_state_e    - decoder control states (idle, counting beats, holding result)
//   sc_elem_width - result element width derived from the stream-length field width
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StHold
    } sc_state_e;

    // One extra bit over the length field: an unsigned count never exceeds
    // stream_len, and the bipolar value 2*count-len spans [-len, +len].
    function automatic int unsigned sc_elem_width(input int unsigned len_w);
        return len_w + 1;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// sc_ones_counter: per-element accumulator counting ones in a stochastic bit stream.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the count
//   clr_i   - synchronous clear (start of a new window)
//   en_i    - accept the current bit
//   bit_i   - stochastic input bit
//   count_o - W-bit count of accepted ones
module sc_ones_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + {{(W-1){1'b0}}, bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sc_matrix_decoder.sv
// sc_matrix_decoder: decodes a BATCH_SIZE x OUTPUT_FEATURES matrix of stochastic bit
// streams into binary values by counting ones over a window of stream_len beats.
// Optional build macro: SC_DECODER_BIPOLAR_EN - elements become signed 2*count-len.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - begin a window (honoured only when idle)
//   stream_len     - number of beats in the window, sampled with start
//   in_valid       - input beat valid; in_ready high while counting
//   inputData      - one bit per element, element (m,o) at bit m*OUTPUT_FEATURES+o
//   out_valid      - decoded matrix available; out_ready consumes it
//   outputData     - decoded matrix, element (m,o) at [(m*OUTPUT_FEATURES+o)*W +: W]
//   busy           - not idle
module sc_matrix_decoder
    import sc_pkg::*;
#(
    parameter int unsigned BATCH_SIZE      = 4,
    parameter int unsigned OUTPUT_FEATURES = 4,
    parameter int unsigned LEN_W           = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic [LEN_W-1:0]                                    stream_len,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]               inputData,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [BATCH_SIZE*OUTPUT_FEATURES*(LEN_W+1)-1:0]     outputData,
    output logic                                                busy
);

    localparam int unsigned W = sc_elem_width(LEN_W);
    localparam int unsigned N = BATCH_SIZE * OUTPUT_FEATURES;

    sc_state_e          state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [N*W-1:0]     out_q, out_d;
    logic [N*W-1:0]     count_flat;
    logic [N*W-1:0]     result_flat;
    logic               clr;
    logic               accept;

`ifdef SC_DECODER_BIPOLAR_EN
    logic [LEN_W-1:0]   len_q, len_d;
`endif

    assign accept = in_valid && (state_q == StCount);

    for (genvar i = 0; i < N; i++) begin : g_cnt
        sc_ones_counter #(
            .W(W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (clr),
            .en_i   (accept),
            .bit_i  (inputData[i]),
            .count_o(count_flat[i*W +: W])
        );
    end

    // Final element values including the beat being accepted this cycle, so the
    // result can be registered on the last beat without an extra cycle.
    always_comb begin
        logic [W-1:0] fin;
        result_flat = '0;
        for (int i = 0; i < N; i++) begin
            fin = count_flat[i*W +: W] + {{(W-1){1'b0}}, inputData[i]};
`ifdef SC_DECODER_BIPOLAR_EN
            // Modulo-2^W arithmetic is exact: the true result lies in [-len, +len].
            result_flat[i*W +: W] = {fin[W-2:0], 1'b0} - {1'b0, len_q};
`else
            result_flat[i*W +: W] = fin;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        out_d   = out_q;
        clr     = 1'b0;
`ifdef SC_DECODER_BIPOLAR_EN
        len_d   = len_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clr   = 1'b1;
                    rem_d = stream_len;
                    out_d = '0;
`ifdef SC_DECODER_BIPOLAR_EN
                    len_d = stream_len;
`endif
                    state_d = (stream_len != '0) ? StCount : StHold;
                end
            end
            StCount: begin
                if (in_valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        out_d   = result_flat;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            out_q   <= '0;
`ifdef SC_DECODER_BIPOLAR_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
`ifdef SC_DECODER_BIPOLAR_EN
            len_q   <= len_d;
`endif
        end
    end

    assign in_ready   = (state_q == StCount);
    assign out_valid  = (state_q == StHold);
    assign busy       = (state_q != StIdle);
    assign outputData = out_q;

endmodule

// File: tb/tb_sc_matrix_decoder.sv
// tb_sc_matrix_decoder: scoreboard bench for sc_matrix_decoder (2x2 matrix, LEN_W=4).
// Expected matrices are computed from per-element ones tallies of the driven beats and
// queued; a monitor pops one on each out_valid rise and checks stability while held.
module tb_sc_matrix_decoder;

    localparam int unsigned B = 2;
    localparam int unsigned O = 2;
    localparam int unsigned L = 4;
    localparam int unsigned W = L + 1;
    localparam int unsigned N = B * O;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [L-1:0]     stream_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     inputData;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   outputData;
    logic             busy;

    int               total = 0;
    int               bad = 0;
    logic [N*W-1:0]   exp_q[$];
    logic [N*W-1:0]   cur;
    bit               seen = 1'b0;
    bit               valid_q[$];
    logic [N-1:0]     beat_q[$];

    sc_matrix_decoder #(
        .BATCH_SIZE     (B),
        .OUTPUT_FEATURES(O),
        .LEN_W          (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stream_len(stream_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inputData (inputData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outputData(outputData),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    // Reference: element value from the number of ones seen and the window length.
    function automatic logic [N*W-1:0] model(input int ones[N], input int len);
        logic [N*W-1:0] r;
        int v;
        r = '0;
        for (int e = 0; e < N; e++) begin
`ifdef SC_DECODER_BIPOLAR_EN
            v = 2 * ones[e] - len;
`else
            v = ones[e];
`endif
            r[e*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    // Starts a window and plays valid_q/beat_q; pushes the expected result if asked.
    task automatic do_window(input int len, input bit push);
        int ones[N];
        logic [N-1:0] b;
        bit v;
        for (int e = 0; e < N; e++) ones[e] = 0;
        start = 1'b1;
        stream_len = len[L-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        while (valid_q.size() > 0) begin
            v = valid_q.pop_front();
            in_valid = v;
            if (v) begin
                b = beat_q.pop_front();
                for (int e = 0; e < N; e++) ones[e] += int'(b[e]);
            end else begin
                b = N'($urandom);
            end
            inputData = b;
            chk("in_ready_counting", in_ready, 1);
            chk("out_valid_low_counting", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(model(ones, len));
            chk("out_valid_after_last", out_valid, 1);
        end
    endtask

    task automatic release_out(input int delay);
        out_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("busy_drop", busy, 0);
    endtask

    task automatic rand_window(input int len);
        int got;
        got = 0;
        while (got < len) begin
            if (($urandom_range(0, 9) < 7) || (valid_q.size() > 40)) begin
                valid_q.push_back(1'b1);
                beat_q.push_back(N'($urandom));
                got++;
            end else begin
                valid_q.push_back(1'b0);
            end
        end
        do_window(len, 1'b1);
    endtask

    // Monitor: one expected matrix per out_valid assertion, held stable until consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got %0h expected none", outputData);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("sb_out_data", outputData, cur);
                    end
                    seen = 1'b1;
                end else begin
                    chk("sb_hold_stable", outputData, cur);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] k;
        rst = 1'b1;
        start = 1'b0;
        stream_len = '0;
        in_valid = 1'b0;
        inputData = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", outputData, 0);
        rst = 1'b0;

        // Idle ignores in_valid without start.
        in_valid = 1'b1;
        inputData = '1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("idle_busy", busy, 0);

        // Directed 8-beat window with known column patterns.
        for (int j = 0; j < 8; j++) begin
            valid_q.push_back(1'b1);
            beat_q.push_back({(j < 6) ? 1'b1 : 1'b0, 1'b0, (j % 2 == 0) ? 1'b1 : 1'b0, 1'b1});
        end
        do_window(8, 1'b1);
`ifdef SC_DECODER_BIPOLAR_EN
        k = {5'd4, 5'b11000, 5'd0, 5'd8};
`else
        k = {5'd6, 5'd0, 5'd4, 5'd8};
`endif
        chk("t1_elems", outputData, k);
        release_out(1);

        // Gapped window: 1,0,0,1,1,0,1 with len=4.
        foreach (k[i]) begin end
        valid_q = '{1, 0, 0, 1, 1, 0, 1};
        for (int j = 0; j < 4; j++) beat_q.push_back(N'($urandom));
        do_window(4, 1'b1);
        release_out(2);

        // Zero-length window goes straight to HOLD with zero data.
        do_window(0, 1'b1);
        chk("len0_data", outputData, 0);
        chk("len0_busy", busy, 1);
        release_out(0);

        // HOLD ignores start and in_valid while out_ready is low.
        for (int j = 0; j < 3; j++) begin
            valid_q.push_back(1'b1);
            beat_q.push_back(N'($urandom));
        end
        do_window(3, 1'b1);
        for (int j = 0; j < 5; j++) begin
            start = 1'b1;
            stream_len = 4'd5;
            in_valid = 1'b1;
            inputData = N'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        // start coincident with the HOLD-to-IDLE transition must be ignored.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        chk("hold_exit_valid", out_valid, 0);
        chk("hold_exit_busy", busy, 0);
        @(posedge clk); #1;
        chk("no_new_window", busy, 0);

        // Reset mid-window discards partial counts.
        start = 1'b1;
        stream_len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            inputData = '1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data", outputData, 0);
        for (int j = 0; j < 2; j++) begin
            valid_q.push_back(1'b1);
            beat_q.push_back(N'($urandom));
        end
        do_window(2, 1'b1);
        release_out(1);

        // Maximum length, all ones: no wrap.
        for (int j = 0; j < 15; j++) begin
            valid_q.push_back(1'b1);
            beat_q.push_back('1);
        end
        do_window(15, 1'b1);
        k = {5'd15, 5'd15, 5'd15, 5'd15};
        chk("len15_elems", outputData, k);
        release_out(1);

        // Randomized windows.
        for (int t = 0; t < 12; t++) begin
            rand_window($urandom_range(1, 15));
            release_out($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_matrix_decoder.md
SC_MATRIX_DECODER -- requirements
Module: sc_matrix_decoder

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 4, meaning rows M of result matrix C.
REQ-002 SHALL have parameter OUTPUT_FEATURES, default 4, meaning columns O of C.
REQ-003 SHALL have parameter LEN_W, default 8, meaning stream-length field width; element result width W = LEN_W+1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning begin a decode window; sampled only in IDLE.
REQ-007 SHALL have port stream_len, input, LEN_W, meaning the number of stream beats to accumulate; sampled with start.
REQ-008 SHALL have port in_valid, input, 1, meaning inputStream carries a valid beat.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts a beat; high only in COUNT.
REQ-010 SHALL have port inputData, input, BATCH_SIZE*OUTPUT_FEATURES, meaning one stochastic bit per element of C, element (m,o) at bit m*OUTPUT_FEATURES+o.
REQ-011 SHALL have port out_valid, output, 1, meaning outputData holds a decoded matrix.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer accepts outputData.
REQ-013 SHALL have port outputData, output, BATCH_SIZE*OUTPUT_FEATURES*W, meaning the decoded binary matrix, element (m,o) at slice [(m*OUTPUT_FEATURES+o)*W +: W].
REQ-014 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, COUNT, HOLD.
REQ-016 IDLE with start=1: latch stream_len into remaining, clear all element counters; go to COUNT if stream_len>0, else go to HOLD with all results zero.
REQ-017 IDLE with start=0: remain in IDLE; in_valid is ignored.
REQ-018 A beat is accepted when in_valid and in_ready are both high; each element counter increments by its input bit and remaining decrements by 1.
REQ-019 Cycles in COUNT without in_valid SHALL change no state.
REQ-020 On the accepted beat with remaining==1, the final counts (including that beat) SHALL be registered into outputData; go to HOLD; out_valid rises on the next cycle.
REQ-021 HOLD: out_valid=1 and outputData stable until out_ready=1; on that cycle go to IDLE; out_valid drops on the next cycle.
REQ-022 start SHALL be ignored in COUNT and HOLD; start in the same cycle as the HOLD-to-IDLE transition SHALL be ignored.
REQ-023 Counters SHALL be W bits and cannot overflow, because count <= stream_len <= 2^LEN_W-1.

Reset
REQ-024 rst=1 SHALL force IDLE, remaining=0, all counters=0, outputData=0, out_valid=0, in_ready=0, and busy=0 on the next edge.
REQ-025 rst SHALL take priority over all other inputs, including mid-COUNT and mid-HOLD; a partial window is discarded.

Configuration
REQ-026 With macro SC_DECODER_BIPOLAR_EN defined, each output element SHALL be the signed two's-complement value 2*count-stream_len in W bits, with range [-len,+len].
REQ-027 Without SC_DECODER_BIPOLAR_EN, each output element SHALL be the unsigned count of ones.
REQ-028 Timing and handshake SHALL be identical in both modes.

Structure
REQ-029 The state enum and the W derivation SHALL reside in shared package sc_pkg.
REQ-030 Per-element accumulation SHALL be sub-module sc_ones_counter (clear, enable, bit in, W-bit count), instantiated BATCH_SIZE*OUTPUT_FEATURES times via generate.

Verification (BATCH_SIZE=2, OUTPUT_FEATURES=2, LEN_W=4)
REQ-031 The bench SHALL apply start, len=8, then 8 consecutive beats with element0 always 1, element1 alternating, element2 always 0, element3 1 on 6 of 8 beats -> out_valid one cycle after beat 8, with elements {8,4,0,6}; bipolar build gives {8,0,-8,4}.
REQ-032 The bench SHALL apply len=4 with in_valid gapped (1,0,0,1,1,0,1) -> exactly 4 beats counted, and in_ready stays high across the gaps.
REQ-033 The bench SHALL apply start with len=0 -> HOLD next cycle, outputData all zero, out_valid=1.
REQ-034 The bench SHALL hold out_ready=0 for 5 cycles in HOLD, pulsing start and in_valid -> outputData unchanged and no new window; out_ready=1 -> IDLE, out_valid=0 the next cycle.
REQ-035 The bench SHALL assert rst after 3 of 8 beats -> all outputs zero next cycle; a fresh len=2 window then yields counts from only the new beats.
REQ-036 The bench SHALL apply len=15 with all bits 1 -> elements = 15 (unsigned) or +15 (bipolar), with no wrap.
